alu_cmd_sequencer: RTL and testbench

Hardware command sequencer and response collector for the 8-bit ALU, sitting between a command source and the ALU's CLK/A/B/S inputs and F/FF/flag outputs. It accepts one operation at a time over a valid/ready handshake and drives A/B/S to the ALU. After a programmable latency it samples the results and returns them over a second valid/ready handshake, with a sequence tag and optional expected-value checking. It replaces hand-sequenced stimulus with a reusable in-fabric driver/checker.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/sat_counter.sv | 22 ++
 rtl/alu_cmd_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: default widths, flag bit
// positions, sequencer state encoding and the ALU opcodes used by command sources.
package alu_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_SEL_W = 4;
   localparam int FLAG_W    = 6;
   localparam int TAG_W     = 8;
   localparam int LAT_W     = 4;

   // Flag vector bit positions, {EQUAL,GT,LT,Zero,CarryOut,Overflow}
   localparam int FLG_EQUAL = 5;
   localparam int FLG_GT    = 4;
   localparam int FLG_LT    = 3;
   localparam int FLG_ZERO  = 2;
   localparam int FLG_COUT  = 1;
   localparam int FLG_OVF   = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } seq_state_t;

   // ALU operation selects as seen on the S input
   localparam logic [DEF_SEL_W-1:0] OP_PASS_A = 4'b0000;
   localparam logic [DEF_SEL_W-1:0] OP_ADD    = 4'b0001;
   localparam logic [DEF_SEL_W-1:0] OP_SUB    = 4'b0010;
   localparam logic [DEF_SEL_W-1:0] OP_AND    = 4'b0011;
   localparam logic [DEF_SEL_W-1:0] OP_OR     = 4'b0100;
   localparam logic [DEF_SEL_W-1:0] OP_XOR    = 4'b0101;
   localparam logic [DEF_SEL_W-1:0] OP_NOT_A  = 4'b0110;
   localparam logic [DEF_SEL_W-1:0] OP_CMP    = 4'b0111;

   // Saturating increment of an 8-bit count
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module sat_counter
   import alu_pkg::*;
#(
   parameter int W = TAG_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count increments, stopping at the maximum value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer / response collector for the 8-bit ALU. Accepts one command,
// holds it on the ALU inputs for ALU_LAT+1 edges, captures the results and returns
// them with a tag and an optional check against an expected F value.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SEL_W   = DEF_SEL_W,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [WIDTH-1:0]  cmd_a,
   input  logic [WIDTH-1:0]  cmd_b,
   input  logic [SEL_W-1:0]  cmd_s,
   input  logic [WIDTH-1:0]  cmd_exp,
   input  logic              cmd_chk,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [SEL_W-1:0]  alu_s,
   input  logic [WIDTH-1:0]  alu_f,
   input  logic [WIDTH-1:0]  alu_ff,
   input  logic [FLAG_W-1:0] alu_flags,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WIDTH-1:0]  rsp_f,
   output logic [WIDTH-1:0]  rsp_ff,
   output logic [FLAG_W-1:0] rsp_flags,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_mismatch,
   output logic [7:0]        err_count,
   output logic              busy
);

   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ALU_LAT);

   seq_state_t        state_reg, state_next;
   logic              accept, capture;
   logic              mismatch_next;

   logic [WIDTH-1:0]  alu_a_reg, alu_b_reg;
   logic [SEL_W-1:0]  alu_s_reg;
   logic [WIDTH-1:0]  exp_reg;
   logic              chk_reg;
   logic [LAT_W-1:0]  cnt_reg;
   logic [TAG_W-1:0]  tag_reg;
   logic [TAG_W-1:0]  cmd_tag_reg;
   logic [WIDTH-1:0]  rsp_f_reg, rsp_ff_reg;
   logic [FLAG_W-1:0] rsp_flags_reg;
   logic              rsp_mismatch_reg;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic plus the accept/capture strobes that steer the datapath
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               accept     = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (cnt_reg == '0) begin
               capture    = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Only F takes part in the check; FF and flags are returned unchecked
   assign mismatch_next = chk_reg && (alu_f != exp_reg);

   // Command side: ALU drive registers, check operands, latency counter and tag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a_reg   <= '0;
         alu_b_reg   <= '0;
         alu_s_reg   <= '0;
         exp_reg     <= '0;
         chk_reg     <= 1'b0;
         cnt_reg     <= '0;
         tag_reg     <= '0;
         cmd_tag_reg <= '0;
      end else if (accept) begin
         alu_a_reg   <= cmd_a;
         alu_b_reg   <= cmd_b;
         alu_s_reg   <= cmd_s;
         exp_reg     <= cmd_exp;
         chk_reg     <= cmd_chk;
         cnt_reg     <= LAT_INIT;
         cmd_tag_reg <= tag_reg;
         tag_reg     <= tag_reg + 1'b1;
      end else if ((state_reg == WAIT) && (cnt_reg != '0)) begin
         cnt_reg     <= cnt_reg - 1'b1;
      end
   end

   // Response side: results are frozen at capture and held until the next capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_f_reg        <= '0;
         rsp_ff_reg       <= '0;
         rsp_flags_reg    <= '0;
         rsp_mismatch_reg <= 1'b0;
      end else if (capture) begin
         rsp_f_reg        <= alu_f;
         rsp_ff_reg       <= alu_ff;
         rsp_flags_reg    <= alu_flags;
         rsp_mismatch_reg <= mismatch_next;
      end
   end

   sat_counter #(
      .W (8)
   ) u_err_count (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (capture && mismatch_next),
      .count (err_count)
   );

   assign cmd_ready    = (state_reg == IDLE);
   assign rsp_valid    = (state_reg == RESP);
   assign busy         = (state_reg != IDLE);
   assign alu_a        = alu_a_reg;
   assign alu_b        = alu_b_reg;
   assign alu_s        = alu_s_reg;
   assign rsp_f        = rsp_f_reg;
   assign rsp_ff       = rsp_ff_reg;
   assign rsp_flags    = rsp_flags_reg;
   assign rsp_tag      = cmd_tag_reg;
   assign rsp_mismatch = rsp_mismatch_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: several instances at different ALU latencies, each
// driving an adder stub ALU; responses are checked against a transaction-level model.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   localparam int N_INST = 5;
   localparam int LATS [N_INST] = '{1, 0, 3, 15, 5};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n        [N_INST];
   logic       cmd_valid    [N_INST];
   logic       cmd_ready    [N_INST];
   logic [7:0] cmd_a        [N_INST];
   logic [7:0] cmd_b        [N_INST];
   logic [3:0] cmd_s        [N_INST];
   logic [7:0] cmd_exp      [N_INST];
   logic       cmd_chk      [N_INST];
   logic [7:0] alu_a        [N_INST];
   logic [7:0] alu_b        [N_INST];
   logic [3:0] alu_s        [N_INST];
   logic [7:0] alu_f        [N_INST];
   logic [7:0] alu_ff       [N_INST];
   logic [5:0] alu_flags    [N_INST];
   logic       rsp_valid    [N_INST];
   logic       rsp_ready    [N_INST];
   logic [7:0] rsp_f        [N_INST];
   logic [7:0] rsp_ff       [N_INST];
   logic [5:0] rsp_flags    [N_INST];
   logic [7:0] rsp_tag      [N_INST];
   logic       rsp_mismatch [N_INST];
   logic [7:0] err_count    [N_INST];
   logic       busy         [N_INST];
   logic [21:0] stub_out    [N_INST];

   int n_cmp = 0;
   int n_bad = 0;
   int tag_model [N_INST];
   int err_model [N_INST];

   // Stub ALU behaviour: {F = A+B, FF = A-B, flags}
   function automatic logic [21:0] alu_model(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s9;
      logic [7:0] f;
      logic [7:0] ff;
      logic [5:0] fl;
      s9 = {1'b0, a} + {1'b0, b};
      f  = s9[7:0];
      ff = a - b;
      fl = {a == b, a > b, a < b, f == 8'h00, s9[8], (a[7] == b[7]) && (f[7] != a[7])};
      return {f, ff, fl};
   endfunction

   for (genvar gi = 0; gi < N_INST; gi++) begin : g_inst
      localparam int LAT = LATS[gi];
      localparam int PI  = (LAT == 0) ? 0 : LAT - 1;
      logic [21:0] pipe [16];

      // Delay line giving the stub its result latency
      always_ff @(posedge clk) begin
         pipe[0] <= alu_model(alu_a[gi], alu_b[gi]);
         for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
      end

      assign stub_out[gi]  = (LAT == 0) ? alu_model(alu_a[gi], alu_b[gi]) : pipe[PI];
      assign alu_f[gi]     = stub_out[gi][21:14];
      assign alu_ff[gi]    = stub_out[gi][13:6];
      assign alu_flags[gi] = stub_out[gi][5:0];

      alu_cmd_sequencer #(
         .WIDTH   (8),
         .SEL_W   (4),
         .ALU_LAT (LAT)
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n[gi]),
         .cmd_valid    (cmd_valid[gi]),
         .cmd_ready    (cmd_ready[gi]),
         .cmd_a        (cmd_a[gi]),
         .cmd_b        (cmd_b[gi]),
         .cmd_s        (cmd_s[gi]),
         .cmd_exp      (cmd_exp[gi]),
         .cmd_chk      (cmd_chk[gi]),
         .alu_a        (alu_a[gi]),
         .alu_b        (alu_b[gi]),
         .alu_s        (alu_s[gi]),
         .alu_f        (alu_f[gi]),
         .alu_ff       (alu_ff[gi]),
         .alu_flags    (alu_flags[gi]),
         .rsp_valid    (rsp_valid[gi]),
         .rsp_ready    (rsp_ready[gi]),
         .rsp_f        (rsp_f[gi]),
         .rsp_ff       (rsp_ff[gi]),
         .rsp_flags    (rsp_flags[gi]),
         .rsp_tag      (rsp_tag[gi]),
         .rsp_mismatch (rsp_mismatch[gi]),
         .err_count    (err_count[gi]),
         .busy         (busy[gi])
      );
   end

   function automatic string tg(input int k, input string name);
      return $sformatf("%s[%0d]", name, k);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic check_reset(input int k);
      check(tg(k, "rst_cmd_ready"), cmd_ready[k], 1);
      check(tg(k, "rst_rsp_valid"), rsp_valid[k], 0);
      check(tg(k, "rst_rsp_f"), rsp_f[k], 0);
      check(tg(k, "rst_rsp_ff"), rsp_ff[k], 0);
      check(tg(k, "rst_rsp_flags"), rsp_flags[k], 0);
      check(tg(k, "rst_rsp_tag"), rsp_tag[k], 0);
      check(tg(k, "rst_rsp_mismatch"), rsp_mismatch[k], 0);
      check(tg(k, "rst_alu_a"), alu_a[k], 0);
      check(tg(k, "rst_alu_b"), alu_b[k], 0);
      check(tg(k, "rst_alu_s"), alu_s[k], 0);
      check(tg(k, "rst_err_count"), err_count[k], 0);
      check(tg(k, "rst_busy"), busy[k], 0);
   endtask

   // One full transaction on instance k; called and returning on a falling edge
   task automatic send_cmd(input int k, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] s, input logic [7:0] e, input logic chk,
                           input int stall);
      logic [21:0] r;
      int          exp_tag;
      logic        exp_mis;
      int          n;
      r       = alu_model(a, b);
      exp_tag = tag_model[k];
      exp_mis = chk && (r[21:14] != e);
      cmd_a[k] = a; cmd_b[k] = b; cmd_s[k] = s; cmd_exp[k] = e; cmd_chk[k] = chk;
      cmd_valid[k] = 1'b1;
      n = 0;
      while (cmd_ready[k] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check(tg(k, "accept_timeout"), cmd_ready[k], 1);
      @(negedge clk);
      tag_model[k] = (tag_model[k] + 1) % 256;
      if (exp_mis && err_model[k] < 255) err_model[k]++;
      n = 0;
      while (rsp_valid[k] !== 1'b1 && n < 40) begin
         // a competing command offered while busy must not disturb anything
         cmd_valid[k] = 1'($urandom_range(0, 1));
         cmd_a[k] = 8'($urandom); cmd_b[k] = 8'($urandom); cmd_s[k] = 4'($urandom);
         check(tg(k, "wait_busy"), busy[k], 1);
         check(tg(k, "wait_cmd_ready"), cmd_ready[k], 0);
         check(tg(k, "wait_alu_abs"), {alu_a[k], alu_b[k], alu_s[k]}, {a, b, s});
         @(negedge clk);
         n++;
      end
      check(tg(k, "latency"), n, LATS[k] + 1);
      check(tg(k, "rsp_f"), rsp_f[k], r[21:14]);
      check(tg(k, "rsp_ff"), rsp_ff[k], r[13:6]);
      check(tg(k, "rsp_flags"), rsp_flags[k], r[5:0]);
      check(tg(k, "rsp_tag"), rsp_tag[k], exp_tag);
      check(tg(k, "rsp_mismatch"), rsp_mismatch[k], exp_mis);
      check(tg(k, "err_count"), err_count[k], err_model[k]);
      check(tg(k, "rsp_cmd_ready"), cmd_ready[k], 0);
      if (stall > 0) begin
         rsp_ready[k] = 1'b0;
         repeat (stall) begin
            cmd_valid[k] = 1'b1;
            @(negedge clk);
            check(tg(k, "stall_valid"), rsp_valid[k], 1);
            check(tg(k, "stall_rsp"), {rsp_f[k], rsp_tag[k], rsp_mismatch[k]},
                  {r[21:14], 8'(exp_tag), exp_mis});
            check(tg(k, "stall_cmd_ready"), cmd_ready[k], 0);
            check(tg(k, "stall_alu_a"), alu_a[k], a);
         end
         rsp_ready[k] = 1'b1;
      end
      cmd_valid[k] = 1'b0;
      @(negedge clk);
      check(tg(k, "rsp_done"), rsp_valid[k], 0);
      check(tg(k, "idle_ready"), cmd_ready[k], 1);
      check(tg(k, "idle_alu_a"), alu_a[k], a);
      $display("txn inst=%0d a=%02h b=%02h s=%0h chk=%0d exp=%02h -> f=%02h tag=%0d mis=%0d err=%0d lat=%0d stall=%0d",
               k, a, b, s, chk, e, rsp_f[k], exp_tag, exp_mis, err_count[k], n, stall);
   endtask

   // Accept a command, then pull reset while the sequencer is still waiting
   task automatic reset_mid_wait(input int k);
      int n;
      cmd_a[k] = 8'h5A; cmd_b[k] = 8'h11; cmd_s[k] = 4'h1; cmd_exp[k] = 8'h00; cmd_chk[k] = 1'b1;
      cmd_valid[k] = 1'b1;
      n = 0;
      while (cmd_ready[k] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      cmd_valid[k] = 1'b0;
      check(tg(k, "pre_reset_busy"), busy[k], 1);
      rst_n[k] = 1'b0;
      #1;
      check_reset(k);
      @(negedge clk);
      rst_n[k] = 1'b1;
      tag_model[k] = 0;
      err_model[k] = 0;
      $display("txn inst=%0d reset asserted mid-WAIT", k);
   endtask

   initial begin
      logic [7:0]  a, b, e;
      logic [21:0] r;
      for (int k = 0; k < N_INST; k++) begin
         rst_n[k] = 1'b1; cmd_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
         cmd_a[k] = '0; cmd_b[k] = '0; cmd_s[k] = '0; cmd_exp[k] = '0; cmd_chk[k] = 1'b0;
         tag_model[k] = 0; err_model[k] = 0;
      end
      #2;
      for (int k = 0; k < N_INST; k++) rst_n[k] = 1'b0;
      #1;
      for (int k = 0; k < N_INST; k++) check_reset(k);
      repeat (3) @(negedge clk);
      for (int k = 0; k < N_INST; k++) rst_n[k] = 1'b1;
      @(negedge clk);

      // Directed cases on the ALU_LAT=1 instance
      send_cmd(0, 8'h0F, 8'h05, 4'b0001, 8'h14, 1'b1, 0);
      send_cmd(0, 8'h0C, 8'h0F, 4'b0001, 8'h00, 1'b1, 0);
      send_cmd(0, 8'h0C, 8'h0F, 4'b0001, 8'h00, 1'b0, 0);
      send_cmd(0, 8'h33, 8'h44, 4'b0010, 8'h77, 1'b1, 5);
      send_cmd(0, 8'hFF, 8'h01, 4'b0001, 8'h00, 1'b1, 0);

      // Random traffic with random backpressure
      for (int i = 0; i < 40; i++) begin
         a = 8'($urandom); b = 8'($urandom);
         r = alu_model(a, b);
         e = ($urandom_range(0, 1) == 1) ? r[21:14] : 8'($urandom);
         send_cmd(0, a, b, 4'($urandom), e, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      // Long all-mismatch run: tag wraps and the error count saturates
      for (int i = 0; i < 300; i++) begin
         a = 8'($urandom); b = 8'($urandom);
         r = alu_model(a, b);
         send_cmd(0, a, b, 4'b0001, r[21:14] ^ 8'h01, 1'b1, 0);
      end
      check("err_saturated", err_count[0], 255);

      // Latency sweep and reset abort on the other instances
      for (int k = 1; k < N_INST; k++) begin
         send_cmd(k, 8'h21 + 8'(k), 8'h10, 4'b0001, 8'h00, 1'b1, 0);
         send_cmd(k, 8'h80, 8'h80 + 8'(k), 4'b0011, 8'h00, 1'b0, 2);
         reset_mid_wait(k);
         send_cmd(k, 8'h07, 8'h09, 4'b0001, 8'h10, 1'b1, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
